// File: rtl/zic_wdt_if.sv
// Watchdog MMR store bus plus the register images and request outputs
// that go to the read mux and the system reset logic.
interface zic_wdt_if;
    logic        zic_mmr_write_en_i;
    logic [15:0] zic_mmr_write_addr_i;
    logic [31:0] zic_mmr_write_data_i;
    logic [31:0] wdt_counter_o;
    logic [31:0] wdt_ctrl_o;
    logic [31:0] wdt_timeout_reg_o;
    logic        wdt_irq_o;
    logic        wdt_rst_o;

    modport master (
        output zic_mmr_write_en_i, zic_mmr_write_addr_i, zic_mmr_write_data_i,
        input  wdt_counter_o, wdt_ctrl_o, wdt_timeout_reg_o, wdt_irq_o, wdt_rst_o
    );

    modport slave (
        input  zic_mmr_write_en_i, zic_mmr_write_addr_i, zic_mmr_write_data_i,
        output wdt_counter_o, wdt_ctrl_o, wdt_timeout_reg_o, wdt_irq_o, wdt_rst_o
    );
endinterface

// File: rtl/zic_wdt.sv
// Two-stage watchdog: first timeout raises an interrupt, a second
// unserviced timeout pulses a system reset request.
module zic_wdt #(
    parameter logic [31:0] KICK_KEY      = 32'h0000_A5A5,
    parameter logic [31:0] TIMEOUT_RST   = 32'hFFFF_FFFF,
    parameter int unsigned RST_PULSE_LEN = 16
) (
    input  logic   clk_i,
    input  logic   rst_i,
    zic_wdt_if.slave bus
);
    localparam int unsigned CNT_W   = 32;
    localparam int unsigned PRESC_W = 8;
    localparam int unsigned PULSE_W = (RST_PULSE_LEN > 1) ? $clog2(RST_PULSE_LEN) : 1;

    localparam logic [15:0] ADDR_CNT  = 16'h080C;
    localparam logic [15:0] ADDR_CTRL = 16'h0810;
    localparam logic [15:0] ADDR_TO   = 16'h0814;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        WARN  = 2'd2,
        BITE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic                 en_q, en_d;
    logic                 irq_en_q, irq_en_d;
    logic                 rst_en_q, rst_en_d;
    logic                 to_flag_q, to_flag_d;
    logic                 badkey_q, badkey_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic [PRESC_W-1:0]   pc_q, pc_d;
    logic [CNT_W-1:0]     counter_q, counter_d;
    logic [CNT_W-1:0]     timeout_q, timeout_d;
    logic [PULSE_W-1:0]   pulse_q, pulse_d;
    logic                 irq_q, irq_d;
    logic                 wrst_q, wrst_d;

    logic        active;
    logic        wr_ctrl;
    logic        wr_to;
    logic        wr_cnt;
    logic        kick;
    logic        bad_key;
    logic        en_off;
    logic        tick;
    logic        to_event;
    logic [31:0] wdata;

    // Store decode; BITE locks out every MMR write.
    assign wdata    = bus.zic_mmr_write_data_i;
    assign active   = (state_q == COUNT) || (state_q == WARN);
    assign wr_ctrl  = bus.zic_mmr_write_en_i && (bus.zic_mmr_write_addr_i == ADDR_CTRL) && (state_q != BITE);
    assign wr_to    = bus.zic_mmr_write_en_i && (bus.zic_mmr_write_addr_i == ADDR_TO) && (state_q == IDLE);
    assign wr_cnt   = bus.zic_mmr_write_en_i && (bus.zic_mmr_write_addr_i == ADDR_CNT) && (state_q != BITE);
    assign kick     = wr_cnt && (wdata == KICK_KEY) && active;
    assign bad_key  = wr_cnt && (wdata != KICK_KEY);
    assign en_off   = wr_ctrl && !wdata[0] && active;
    assign tick     = active && (pc_q == presc_q);
    assign to_event = tick && (counter_q == timeout_q) && !kick && !en_off;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            en_q      <= 1'b0;
            irq_en_q  <= 1'b0;
            rst_en_q  <= 1'b0;
            to_flag_q <= 1'b0;
            badkey_q  <= 1'b0;
            presc_q   <= '0;
            pc_q      <= '0;
            counter_q <= '0;
            timeout_q <= TIMEOUT_RST;
            pulse_q   <= '0;
            irq_q     <= 1'b0;
            wrst_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            en_q      <= en_d;
            irq_en_q  <= irq_en_d;
            rst_en_q  <= rst_en_d;
            to_flag_q <= to_flag_d;
            badkey_q  <= badkey_d;
            presc_q   <= presc_d;
            pc_q      <= pc_d;
            counter_q <= counter_d;
            timeout_q <= timeout_d;
            pulse_q   <= pulse_d;
            irq_q     <= irq_d;
            wrst_q    <= wrst_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        en_d      = en_q;
        irq_en_d  = irq_en_q;
        rst_en_d  = rst_en_q;
        presc_d   = presc_q;
        pc_d      = pc_q;
        counter_d = counter_q;
        timeout_d = timeout_q;
        pulse_d   = pulse_q;

        if (wr_ctrl) begin
            en_d     = wdata[0];
            irq_en_d = wdata[1];
            rst_en_d = wdata[2];
            presc_d  = wdata[15:8];
        end
        if (wr_to) begin
            timeout_d = wdata;
        end

        // Sets win over a same-cycle write-1-to-clear.
        to_flag_d = (to_flag_q & ~(wr_ctrl & wdata[3])) | to_event;
        badkey_d  = (badkey_q & ~(wr_ctrl & wdata[4])) | bad_key;

        unique case (state_q)
            IDLE: begin
                counter_d = '0;
                pc_d      = '0;
                if (wr_ctrl && wdata[0]) begin
                    state_d = COUNT;
                end
            end
            COUNT, WARN: begin
                if (kick) begin
                    counter_d = '0;
                    pc_d      = '0;
                    state_d   = COUNT;
                end else if (en_off) begin
                    counter_d = '0;
                    pc_d      = '0;
                    state_d   = IDLE;
                end else if (tick) begin
                    pc_d = '0;
                    if (counter_q == timeout_q) begin
                        counter_d = '0;
                        if (state_q == COUNT) begin
                            state_d = WARN;
                        end else if (rst_en_q) begin
                            state_d = BITE;
                            pulse_d = '0;
                        end
                    end else begin
                        counter_d = CNT_W'(counter_q + 32'd1);
                    end
                end else begin
                    pc_d = PRESC_W'(pc_q + 8'd1);
                end
            end
            BITE: begin
                pc_d      = '0;
                counter_d = '0;
                if (pulse_q == PULSE_W'(RST_PULSE_LEN - 1)) begin
                    state_d = IDLE;
                    en_d    = 1'b0;
                    pulse_d = '0;
                end else begin
                    pulse_d = PULSE_W'(pulse_q + 1'b1);
                end
            end
            default: state_d = IDLE;
        endcase

        irq_d  = to_flag_d & irq_en_d;
        wrst_d = (state_d == BITE);
    end

    assign bus.wdt_counter_o     = counter_q;
    assign bus.wdt_timeout_reg_o = timeout_q;
    assign bus.wdt_ctrl_o        = {16'h0000, presc_q, 1'b0, state_q, badkey_q, to_flag_q,
                                    rst_en_q, irq_en_q, en_q};
    assign bus.wdt_irq_o         = irq_q;
    assign bus.wdt_rst_o         = wrst_q;
endmodule

// File: doc/zic_wdt.md
# zic_wdt

Two-stage watchdog timer for the Zilla interrupt controller. It owns the watchdog MMRs at 0x080C (counter/kick), 0x0810 (control) and 0x0814 (timeout), and decodes processor store writes to them. It drives the `wdt_counter_i`, `wdt_ctrl_i` and `wdt_timeout_reg_i` inputs of the MMR read multiplexer directly. On a first timeout it raises an interrupt request; on a second unserviced timeout it pulses a system reset request.

## Interface
- `KICK_KEY`, default 32'h0000_A5A5: write value to 0x080C that services the watchdog.
- `TIMEOUT_RST`, default 32'hFFFF_FFFF: reset value of the timeout register.
- `RST_PULSE_LEN`, default 16: cycles `wdt_rst_o` stays high in BITE (≥1).
- `clk_i` in 1: single clock.
- `rst_i` in 1: reset; synchronous, active-high.
- `zic_mmr_write_en_i` in 1: store strobe, one cycle per write.
- `zic_mmr_write_addr_i` in 16: store address, full 16-bit decode.
- `zic_mmr_write_data_i` in 32: store data.
- `wdt_counter_o` out 32: current count, to the read mux.
- `wdt_ctrl_o` out 32: control/status image, to the read mux.
- `wdt_timeout_reg_o` out 32: timeout compare value, to the read mux.
- `wdt_irq_o` out 1: level interrupt request, equal to TO_FLAG & IRQ_EN.
- `wdt_rst_o` out 1: system reset request pulse.

## Operation
- **Control layout (`wdt_ctrl_o`)**
  - [0] EN
  - [1] IRQ_EN
  - [2] RST_EN
  - [3] TO_FLAG: sticky, write-1-to-clear.
  - [4] BADKEY: sticky, write-1-to-clear.
  - [6:5] state: IDLE=0, COUNT=1, WARN=2, BITE=3. Read-only.
  - [15:8] PRESC
  - All other bits read 0 and ignore writes.
- **Writes to 0x0810**
  - Update EN, IRQ_EN, RST_EN and PRESC.
  - Writing 1 to bit 3 or bit 4 clears that flag. Writing 0 leaves it unchanged.
- **Writes to 0x0814**
  - Accepted only in IDLE. Ignored otherwise.
- **Writes to 0x080C**
  - Data == KICK_KEY in COUNT or WARN is a kick: counter←0, prescaler←0, state←COUNT.
  - Any other data sets BADKEY and has no other effect. A kick in IDLE has no effect.
- **Tick generation**
  - Prescaler `pc` counts 0..PRESC. A tick occurs on the cycle where pc==PRESC, and pc returns to 0.
- **Counting (on each tick in COUNT or WARN)**
  - If counter==timeout: counter←0 and a timeout event occurs.
  - Otherwise counter←counter+1.
  - Period between events = (timeout+1)·(PRESC+1) cycles. timeout=0 gives an event on every tick.
- **FSM**
  - IDLE→COUNT when EN=1. Counter and prescaler start from 0.
  - COUNT, on event: TO_FLAG←1, state→WARN.
  - WARN, on event:
    - RST_EN=1: state→BITE.
    - RST_EN=0: stay in WARN. Counter wraps and the flag stays set.
  - COUNT or WARN, on EN written 0: state→IDLE, counter←0, pc←0. Flags are retained.
  - BITE: `wdt_rst_o`=1 for RST_PULSE_LEN cycles. Then state→IDLE, EN←0, counter←0. TO_FLAG is retained.
  - All MMR writes are ignored during BITE.
- **Priority within a cycle**
  - rst_i > kick > EN=0 write > timeout event > increment.
  - A flag W1C and a flag set in the same cycle: set wins.
- **Scope**
  - The block does not reset itself from `wdt_rst_o`. Only `rst_i` clears it.

## Timing
- All outputs are registered.
- A write in cycle N is visible on the outputs in cycle N+1.
- Values after `rst_i`:
  - counter = 0, timeout = TIMEOUT_RST.
  - ctrl = 0 (state IDLE).
  - `wdt_irq_o` = 0, `wdt_rst_o` = 0.
  - Internal pc and pulse counter = 0.
- `rst_i` asserted mid-BITE drops `wdt_rst_o` in the next cycle.
- Event→flag latency: a tick with counter==timeout at edge N sets TO_FLAG, `wdt_irq_o` and state WARN visible in cycle N+1.
- First event: with EN written in cycle 0, counter reads 0 in cycle 1, then increments every PRESC+1 cycles. `wdt_irq_o` rises in cycle 1+(timeout+1)·(PRESC+1).
- WARN→BITE: `wdt_rst_o` rises the cycle after the second event. It holds for exactly RST_PULSE_LEN cycles.
- Counter, timeout and pc are unsigned 32/32/8-bit. A counter can never exceed timeout, so there is no overflow.

## Test plan
- **Reset values:** assert rst_i for 2 cycles → counter 0, ctrl 0, timeout 32'hFFFF_FFFF, irq 0, rst 0.
- **First timeout:**
  - Stimulus: timeout=3, ctrl=32'h0000_0003 (PRESC=0) written in cycle 0.
  - Response: counter 0,1,2,3,0 in cycles 1–5. irq=1 and ctrl[6:5]=2 from cycle 5.
- **Kick in WARN:**
  - Stimulus: from the previous scenario, write 32'h0000_A5A5 to 0x080C.
  - Response: next cycle state=COUNT, counter=0, TO_FLAG still 1.
  - Then W1C 32'h0000_000B to 0x0810 → irq=0 next cycle.
- **Bite:**
  - Stimulus: timeout=1, PRESC=1, ctrl=32'h0000_0107.
  - Response: first event after 4 cycles, then WARN. `wdt_rst_o` high 4 cycles later, for exactly 16 cycles. Afterwards state IDLE, EN=0, TO_FLAG=1.
- **Bad key and kick-versus-event:**
  - Write 32'h1234_5678 to 0x080C → BADKEY=1, counter continues.
  - Kick in the same cycle as the counter==timeout tick → counter=0, no TO_FLAG set.
- **Guard cases:**
  - Write timeout while EN=1 → value unchanged.
  - Write EN=0 during WARN → IDLE and irq stays 1 (flag retained, IRQ_EN=1).
  - Any write during BITE → ignored.
